// File: rtl/bcd2binary_serial_pkg.sv
// -----------------------------------------------------------------------------
// bcd2binary_serial_pkg
// Shared definitions for the serial BCD-to-binary converter:
//   - state_e       : converter FSM state encoding
//   - calc_bin_w()  : binary width needed to hold the largest DIGITS-digit
//                     decimal value, ceil(log2(10^digits))
//   - digit_ok()    : true when a 4-bit BCD digit is a legal decimal digit
// -----------------------------------------------------------------------------
package bcd2binary_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DIGITS_MIN = 2;
    localparam int DIGITS_MAX = 4;

    // Width of the binary result for a given digit count: 7/10/14 for 2/3/4.
    function automatic int calc_bin_w(input int digits);
        int pow10;
        pow10 = 1;
        for (int d = 0; d < digits; d++) begin
            pow10 = pow10 * 10;
        end
        return $clog2(pow10);
    endfunction

    // A BCD digit is legal only in the range 0..9.
    function automatic logic digit_ok(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd2binary_serial_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Per-digit correction step of reverse double-dabble: after a right shift a
// digit that reads 8 or more has received a "half ten" (weight 8 instead of 5)
// from the digit above, so 3 is subtracted. Never underflows (>=8 - 3 >= 5).
// Ports:
//   i_digit  in  4 : BCD digit after the shift
//   o_digit  out 4 : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import bcd2binary_serial_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Subtract 3 from digits of 8 or more, pass others through.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd8) begin
            o_digit = i_digit - 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bcd2binary_serial.sv
// -----------------------------------------------------------------------------
// bcd2binary_serial
// Sequential BCD-to-binary converter using iterative shift-right / subtract-3.
// One conversion in flight; start/done handshake. All outputs registered.
// Parameters:
//   DIGITS  : number of BCD digits (2..4)
//   BIN_W   : binary width, must equal calc_bin_w(DIGITS)
// Ports:
//   Clk      in  1          : rising-edge clock
//   reset    in  1          : asynchronous active-low reset
//   start    in  1          : conversion request, honoured in IDLE only
//   bcd_in   in  4*DIGITS   : packed BCD, digit 0 in [3:0]
//   busy     out 1          : high while shifting
//   done     out 1          : one-cycle result-valid pulse
//   err      out 1          : last accepted request had a digit > 9
//   bin_out  out BIN_W      : last result, held until the next done
// -----------------------------------------------------------------------------
module bcd2binary_serial
    import bcd2binary_serial_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    // Elaboration-time sanity checks on the parameter pair.
    if (BIN_W != calc_bin_w(DIGITS)) begin : g_bad_bin_w
        $error("bcd2binary_serial: BIN_W does not match ceil(log2(10^DIGITS))");
    end
    if ((DIGITS < DIGITS_MIN) || (DIGITS > DIGITS_MAX)) begin : g_bad_digits
        $error("bcd2binary_serial: DIGITS must be in 2..4");
    end

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SR_W-1:0]     r_shift;
    logic [SR_W-1:0]     w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic [BIN_W-1:0]    w_bin_nxt;

    logic                w_bcd_ok;
    logic [SR_W-1:0]     w_shifted;
    logic [BCD_W-1:0]    w_adj_bcd;
    logic [SR_W-1:0]     w_shift_step;

    // Input validity: every digit of the request must be 0..9.
    always_comb begin
        w_bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_ok(bcd_in[4*i +: 4])) begin
                w_bcd_ok = 1'b0;
            end else begin
                w_bcd_ok = w_bcd_ok;
            end
        end
    end

    // One iteration: shift the {bcd, bin} register right, then correct each
    // BCD digit that has picked up an 8 from the digit above.
    assign w_shifted = r_shift >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (w_shifted[BIN_W + 4*g +: 4]),
            .o_digit (w_adj_bcd[4*g +: 4])
        );
    end

    assign w_shift_step = {w_adj_bcd, w_shifted[BIN_W-1:0]};

    // Next-state and next-output logic for the converter FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = err;
        w_bin_nxt   = bin_out;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_bcd_ok) begin
                        w_shift_nxt = {bcd_in, {BIN_W{1'b0}}};
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_err_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        // Rejected request: report at once, no shifting.
                        w_err_nxt   = 1'b1;
                        w_bin_nxt   = {BIN_W{1'b0}};
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_shift_nxt = w_shift_step;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    // Last shift: the bin field now holds the full result.
                    w_bin_nxt   = w_shift_step[BIN_W-1:0];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shift <= {SR_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= {BIN_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            err     <= w_err_nxt;
            bin_out <= w_bin_nxt;
        end
    end

endmodule

// File: tb/tb_bcd2binary_serial.sv
// -----------------------------------------------------------------------------
// tb_bcd2binary_serial
// Two converters share clock and reset: u_dut2 (2 digits, 7-bit result) and
// u_dut3 (3 digits, 10-bit result). A transaction-level model predicts every
// output of both on every cycle from the request timing rules and decimal
// arithmetic; directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd2binary_serial;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        st2   = 1'b0;
    logic        st3   = 1'b0;
    logic [7:0]  bcd2  = 8'h00;
    logic [11:0] bcd3  = 12'h000;

    logic        busy2, done2, err2;
    logic [6:0]  bin2;
    logic        busy3, done3, err3;
    logic [9:0]  bin3;

    always #5 clk = ~clk;

    bcd2binary_serial #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .Clk(clk), .reset(rst_n), .start(st2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .err(err2), .bin_out(bin2)
    );

    bcd2binary_serial #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .Clk(clk), .reset(rst_n), .start(st3), .bcd_in(bcd3),
        .busy(busy3), .done(done3), .err(err3), .bin_out(bin3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Decimal value of a packed BCD word, -1 if any digit exceeds 9.
    function automatic int bcd_value(input logic [15:0] b, input int d);
        int v;
        int mul;
        v = 0;
        mul = 1;
        for (int i = 0; i < d; i++) begin
            if (b[4*i +: 4] > 4'd9) return -1;
            v += int'(b[4*i +: 4]) * mul;
            mul *= 10;
        end
        return v;
    endfunction

    // ---------------- model: per-DUT request timeline ----------------
    int cyc = 0;
    int m_k[2]       = '{0, 0};   // edge that accepted the last request
    int m_free[2]    = '{0, 0};   // earliest edge that may accept again
    int m_binat[2]   = '{0, 0};   // cycle from which bin_out shows m_bin_new
    int m_bin_old[2] = '{0, 0};
    int m_bin_new[2] = '{0, 0};
    bit m_pend[2]    = '{1'b0, 1'b0};
    bit m_valid[2]   = '{1'b0, 1'b0};
    bit m_err[2]     = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_accept(input int i, input int e, input int v, input int w);
        m_bin_old[i] <= (e >= m_binat[i]) ? m_bin_new[i] : m_bin_old[i];
        m_k[i]       <= e;
        m_pend[i]    <= 1'b1;
        m_valid[i]   <= (v >= 0);
        m_err[i]     <= (v < 0);
        m_bin_new[i] <= (v >= 0) ? v : 0;
        m_binat[i]   <= (v >= 0) ? e + w : e;
        m_free[i]    <= (v >= 0) ? e + w + 2 : e + 2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i]    <= 1'b0;
                m_valid[i]   <= 1'b0;
                m_err[i]     <= 1'b0;
                m_bin_old[i] <= 0;
                m_bin_new[i] <= 0;
                m_binat[i]   <= 0;
                m_free[i]    <= 0;
                m_k[i]       <= 0;
            end
        end else begin
            if (st2 && (cyc >= m_free[0])) model_accept(0, cyc, bcd_value({8'h00, bcd2}, 2), 7);
            if (st3 && (cyc >= m_free[1])) model_accept(1, cyc, bcd_value({4'h0, bcd3}, 3), 10);
        end
    end

    task automatic cmp(input int i, input logic b, input logic d, input logic e,
                       input int bin, input int w);
        int c, eb, ed, ebin;
        c    = cyc - 1;
        eb   = (m_pend[i] && m_valid[i] && c >= m_k[i] && c <= m_k[i] + w - 1) ? 1 : 0;
        ed   = (m_pend[i] && c == (m_valid[i] ? m_k[i] + w : m_k[i])) ? 1 : 0;
        ebin = (c >= m_binat[i]) ? m_bin_new[i] : m_bin_old[i];
        check($sformatf("dut%0d busy c=%0d", i, c), int'(b), eb);
        check($sformatf("dut%0d done c=%0d", i, c), int'(d), ed);
        check($sformatf("dut%0d err c=%0d", i, c), int'(e), int'(m_err[i]));
        check($sformatf("dut%0d bin c=%0d", i, c), bin, ebin);
    endtask

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        cmp(0, busy2, done2, err2, int'(bin2), 7);
        cmp(1, busy3, done3, err3, int'(bin3), 10);
    end

    // ---------------- directed stimulus ----------------
    task automatic conv2(input logic [7:0] b, input int exp_bin, input int exp_err,
                         input int exp_lat, input string nm);
        int lat;
        bit seen;
        repeat (2) @(negedge clk);
        st2 = 1'b1;
        bcd2 = b;
        seen = 1'b0;
        lat = 0;
        for (int j = 1; j <= 20 && !seen; j++) begin
            @(negedge clk);
            if (j == 1) st2 = 1'b0;
            if (done2 === 1'b1) begin
                seen = 1'b1;
                lat = j;
            end
        end
        check({nm, " latency"}, lat, exp_lat);
        if (seen) begin
            check({nm, " bin_out"}, int'(bin2), exp_bin);
            check({nm, " err"}, int'(err2), exp_err);
        end
    endtask

    initial begin
        int ndone;
        int got_bin;
        int prev_t;
        int pulses;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy2", int'(busy2), 0);
        check("reset done2", int'(done2), 0);
        check("reset err2", int'(err2), 0);
        check("reset bin2", int'(bin2), 0);
        check("reset bin3", int'(bin3), 0);
        #2 rst_n = 1'b1;

        conv2(8'h42, 42, 0, 8, "h42");
        conv2(8'h99, 99, 0, 8, "h99");
        conv2(8'h00, 0, 0, 8, "h00");
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                conv2({4'(t), 4'(o)}, t * 10 + o, 0, 8, $sformatf("sweep %0d%0d", t, o));
            end
        end

        // Invalid digit, then a valid request clears err
        conv2(8'h9A, 0, 1, 1, "h9A");
        conv2(8'h15, 15, 0, 8, "h15");

        // Start while busy is ignored
        repeat (2) @(negedge clk);
        st2 = 1'b1;
        bcd2 = 8'h37;
        @(negedge clk);
        st2 = 1'b0;
        repeat (2) @(negedge clk);
        st2 = 1'b1;
        bcd2 = 8'h12;
        @(negedge clk);
        st2 = 1'b0;
        ndone = 0;
        got_bin = -1;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                ndone++;
                got_bin = int'(bin2);
            end
        end
        check("busy-start done count", ndone, 1);
        check("busy-start bin_out", got_bin, 37);

        // Reset mid-conversion
        repeat (2) @(negedge clk);
        st2 = 1'b1;
        bcd2 = 8'h64;
        @(negedge clk);
        st2 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy2", int'(busy2), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset busy2", int'(busy2), 0);
        check("mid-reset done2", int'(done2), 0);
        check("mid-reset err2", int'(err2), 0);
        check("mid-reset bin2", int'(bin2), 0);
        ndone = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done2 === 1'b1) ndone++;
        end
        check("mid-reset no done", ndone, 0);
        #2 rst_n = 1'b1;
        conv2(8'h64, 64, 0, 8, "h64 after reset");

        // Back-to-back on the 3-digit converter
        @(negedge clk);
        st3 = 1'b1;
        bcd3 = 12'h999;
        pulses = 0;
        prev_t = -1;
        for (int j = 0; j < 60 && pulses < 3; j++) begin
            @(negedge clk);
            if (done3 === 1'b1) begin
                check("b2b bin3", int'(bin3), 999);
                if (prev_t >= 0) check("b2b period", j - prev_t, 12);
                prev_t = j;
                pulses++;
            end
        end
        check("b2b pulses", pulses, 3);
        st3 = 1'b0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
